// File: rtl/cam_pkg.sv
// ============================================================================
// cam_pkg : shared constants, state encoding and RGB565 helpers for the
//           camera capture path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cam_pkg;

  localparam int CAM_H    = 640;
  localparam int CAM_V    = 480;
  localparam int FB_W     = CAM_H / 2;
  localparam int FB_DEPTH = FB_W * (CAM_V / 2);
  localparam int ADDR_W   = 17;
  localparam int CNT_W    = 10;

  localparam logic [5:0] BIN_THRESH = 6'd24;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_FRAME = 2'd2
  } state_t;

  // Weighted luma ((R<<1) + G + (B<<1)) >> 2; max sum is 187, so 6 bits suffice.
  function automatic logic [5:0] rgb565_luma(input logic [15:0] pix);
    logic [7:0] sum;
    sum = {2'b00, pix[R_MSB:R_LSB], 1'b0}
        + {2'b00, pix[G_MSB:G_LSB]}
        + {2'b00, pix[B_MSB:B_LSB], 1'b0};
    return sum[7:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cam_sync_edge.sv
// ============================================================================
// cam_sync_edge : 2-flop synchronizer with a third flop for rise/fall detect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

`default_nettype wire

// File: rtl/cam_frame_capture.sv
// ============================================================================
// cam_frame_capture : samples an 8-bit RGB565 camera stream, decimates 2:1 in
//   each axis and writes kept pixels linearly into the frame buffer.
//   Optional macro CAM_CAPTURE_BINARIZE_EN: black/white output, +1 cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int LINE_PIX    = CAM_H,
  parameter int FRAME_LINES = CAM_V
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              busy
);

  localparam int                DEPTH   = (LINE_PIX / 2) * (FRAME_LINES / 2);
  localparam logic [CNT_W-1:0]  COL_END = CNT_W'(LINE_PIX);
  localparam logic [CNT_W-1:0]  ROW_END = CNT_W'(FRAME_LINES);
  localparam logic [ADDR_W-1:0] PTR_END = ADDR_W'(DEPTH);

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vsync_lvl, vsync_rise, vsync_fall;

  cam_sync_edge u_sync_pclk (
    .clk      (clk25),
    .rst_n    (rst_n),
    .async_in (cam_pclk),
    .level    (pclk_lvl),
    .rise     (pclk_rise),
    .fall     (pclk_fall)
  );

  cam_sync_edge u_sync_href (
    .clk      (clk25),
    .rst_n    (rst_n),
    .async_in (cam_href),
    .level    (href_lvl),
    .rise     (href_rise),
    .fall     (href_fall)
  );

  cam_sync_edge u_sync_vsync (
    .clk      (clk25),
    .rst_n    (rst_n),
    .async_in (cam_vsync),
    .level    (vsync_lvl),
    .rise     (vsync_rise),
    .fall     (vsync_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{pclk_lvl, pclk_fall, href_rise, vsync_lvl};

  // Data bus stage 2 lines up with the pclk edge detected from stage 2/3.
  logic [7:0] data_s1;
  logic [7:0] data_s2;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
    end else begin
      data_s1 <= cam_data;
      data_s2 <= data_s1;
    end
  end

  state_t            state;
  logic              tog;
  logic [7:0]        hi_byte;
  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  row;
  logic [ADDR_W-1:0] wptr;
  logic              pix_vld;
  logic [ADDR_W-1:0] pix_addr;
  logic [15:0]       pix_data;

  logic              byte_stb;
  logic              keep;
  logic [ADDR_W-1:0] ptr_after;

  assign byte_stb  = (state == S_FRAME) & pclk_rise & href_lvl & ~href_fall;
  assign keep      = byte_stb & tog & ~col[0] & ~row[0]
                   & (col < COL_END) & (row < ROW_END) & (wptr != PTR_END);
  // Counts a write issued in the same cycle as the closing vsync edge.
  assign ptr_after = keep ? wptr + ADDR_W'(1) : wptr;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      tog        <= 1'b0;
      hi_byte    <= 8'h00;
      col        <= '0;
      row        <= '0;
      wptr       <= '0;
      pix_vld    <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      pix_vld    <= keep;
      if (keep) begin
        pix_addr <= wptr;
        pix_data <= {hi_byte, data_s2};
        wptr     <= wptr + ADDR_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (capture_en) state <= S_ARM;
        end
        S_ARM: begin
          if (vsync_fall) begin
            state <= S_FRAME;
            busy  <= 1'b1;
            tog   <= 1'b0;
            col   <= '0;
            row   <= '0;
            wptr  <= '0;
          end
        end
        S_FRAME: begin
          if (href_fall) begin
            tog <= 1'b0;
            col <= '0;
            if (row != ROW_END) row <= row + CNT_W'(1);
          end else if (byte_stb) begin
            if (!tog) begin
              hi_byte <= data_s2;
              tog     <= 1'b1;
            end else begin
              tog <= 1'b0;
              if (col != COL_END) col <= col + CNT_W'(1);
            end
          end
          if (vsync_rise) begin
            frame_done <= 1'b1;
            frame_ok   <= (ptr_after == PTR_END);
            busy       <= 1'b0;
            state      <= capture_en ? S_ARM : S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAM_CAPTURE_BINARIZE_EN
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 16'h0000;
    end else begin
      wr_en   <= pix_vld;
      wr_addr <= pix_addr;
      wr_data <= (rgb565_luma(pix_data) >= BIN_THRESH) ? 16'hFFFF : 16'h0000;
    end
  end
`else
  assign wr_en   = pix_vld;
  assign wr_addr = pix_addr;
  assign wr_data = pix_data;
`endif

endmodule

`default_nettype wire
